// File: rtl/useq_pkg.sv
// useq_pkg: microword layout, am2910 opcodes and control-store FSM types; UCODE_PARITY_EN appends an even-parity MSB
package useq_pkg;

    localparam int OFS_I     = 0;
    localparam int I_W       = 4;
    localparam int OFS_CCEN  = 4;
    localparam int OFS_CCSEL = 5;

    typedef enum logic [3:0] {
        JZ, CJS, JMAP, CJP, PUSH, JSRP, CJV, JRP,
        RFCT, RPCT, CRTN, CJPP, LDCT, LOOP, CONT, TWB
    } instr_e;

    typedef enum logic [1:0] {ST_IDLE, ST_JZ, ST_RUN, ST_HALT} state_e;

    // CONT with CI=0 keeps the sequencer uPC frozen
    localparam logic [3:0] HOLD_I = 4'(CONT);

    function automatic int ccw_of(input int ncc);
        return (ncc > 1) ? $clog2(ncc) : 1;
    endfunction

    function automatic int w_of(input int aw, input int ctrl_w, input int ncc);
`ifdef UCODE_PARITY_EN
        return 9 + ccw_of(ncc) + aw + ctrl_w;
`else
        return 8 + ccw_of(ncc) + aw + ctrl_w;
`endif
    endfunction

    function automatic logic is_push(input logic [3:0] i);
        return i == CJS || i == PUSH || i == JSRP;
    endfunction

endpackage

// File: rtl/useq_ucode_ram.sv
// useq_ucode_ram: single write port, registered read port, no reset on contents
module useq_ucode_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 38
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // write and registered read share the edge; a same-address read returns the old word
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/useq_ctrl_store.sv
// useq_ctrl_store: am2910 control store, pipeline register and run control; UCODE_PARITY_EN adds word parity and par_err
module useq_ctrl_store
    import useq_pkg::*;
#(
    parameter int AW     = 12,
    parameter int OPW    = 8,
    parameter int CTRL_W = 16,
    parameter int NCC    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [AW-1:0]                    y_in,
    input  logic                             map_en,
    input  logic                             vect_en,
    input  logic                             full_in,
    output logic [3:0]                       seq_i,
    output logic                             seq_ccen_bar,
    output logic                             seq_cc_bar,
    output logic                             seq_rld_bar,
    output logic                             seq_ci,
    output logic [AW-1:0]                    seq_d,
    output logic [CTRL_W-1:0]                ctrl_out,
    input  logic                             wr_en,
    input  logic                             wr_map,
    input  logic [AW-1:0]                    wr_addr,
    input  logic [w_of(AW, CTRL_W, NCC)-1:0] wr_data,
    input  logic                             start,
    input  logic                             op_valid,
    input  logic [OPW-1:0]                   op_data,
    output logic                             op_ready,
    input  logic [NCC-1:0]                   cc_in,
    input  logic                             irq,
    input  logic [AW-1:0]                    irq_vec,
    output logic                             irq_ack,
    output logic                             halted,
`ifdef UCODE_PARITY_EN
    output logic                             par_err,
`endif
    output logic                             stk_ovf
);

    localparam int CCW    = ccw_of(NCC);
    localparam int O_RLD  = OFS_CCSEL + CCW;
    localparam int O_CI   = O_RLD + 1;
    localparam int O_HALT = O_CI + 1;
    localparam int O_BR   = O_HALT + 1;
    localparam int O_CTRL = O_BR + AW;
    localparam int BW     = O_CTRL + CTRL_W;
    localparam int W      = w_of(AW, CTRL_W, NCC);
    localparam logic [BW-1:0] HOLD_BASE = BW'(HOLD_I) | (BW'(1) << OFS_CCEN) | (BW'(1) << O_RLD);
`ifdef UCODE_PARITY_EN
    localparam logic [W-1:0] HOLD = {^HOLD_BASE, HOLD_BASE};
`else
    localparam logic [W-1:0] HOLD = HOLD_BASE;
`endif

    state_e         state, state_nxt;
    logic           hold_q, hold_nxt, run, load_ok, halt_now, stk_trip, par_bad, vect_take;
    logic           op_full, op_full_nxt, irq_pend;
    logic [OPW-1:0] op_q, op_nxt;
    logic [NCC-1:0] cc_q;
    logic [W-1:0]   ram_q, pipe;
    logic [AW-1:0]  map_q, ucode_ra;

    assign run         = state == ST_RUN;
    assign load_ok     = state == ST_IDLE || state == ST_HALT;
    assign ucode_ra    = (state == ST_JZ) ? '0 : y_in;
    // the RAM output register is the pipeline; hold_q overrides it with the HOLD word
    assign pipe        = hold_q ? HOLD : ram_q;
    assign stk_trip    = run && is_push(pipe[OFS_I +: I_W]) && full_in;
`ifdef UCODE_PARITY_EN
    assign par_bad     = run && ^pipe;
`else
    assign par_bad     = 1'b0;
`endif
    assign halt_now    = run && (pipe[O_HALT] || stk_trip || par_bad);
    assign vect_take   = run && vect_en && irq_pend;
    assign op_nxt      = (op_valid && op_ready) ? op_data : op_q;
    assign op_full_nxt = (op_valid && op_ready) || (op_full && !(run && map_en));

    useq_ucode_ram #(.ADDR_W(AW), .DATA_W(W)) u_ucode (
        .clk(clk), .we(wr_en && !wr_map && load_ok), .waddr(wr_addr), .wdata(wr_data),
        .raddr(ucode_ra), .rdata(ram_q)
    );

    // map read is addressed by the next opcode so map_q always tracks op_q
    useq_ucode_ram #(.ADDR_W(OPW), .DATA_W(AW)) u_map (
        .clk(clk), .we(wr_en && wr_map && load_ok), .waddr(wr_addr[OPW-1:0]), .wdata(wr_data[AW-1:0]),
        .raddr(op_nxt), .rdata(map_q)
    );

    // next state and pipeline-hold select
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_JZ;
            ST_JZ:   state_nxt = ST_RUN;
            ST_RUN:  if (halt_now) state_nxt = ST_HALT;
            ST_HALT: if (start) state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
        hold_nxt = !(state == ST_JZ || (run && !halt_now));
    end

    // FSM, opcode handshake, vector latch, condition register and sticky fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_q   <= 1'b1;
            op_q     <= '0;
            op_full  <= 1'b0;
            op_ready <= 1'b0;
            irq_pend <= 1'b0;
            irq_ack  <= 1'b0;
            cc_q     <= '0;
            stk_ovf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_q   <= hold_nxt;
            op_q     <= op_nxt;
            op_full  <= op_full_nxt;
            op_ready <= !op_full_nxt;
            irq_pend <= !vect_take && (irq_pend || irq);
            irq_ack  <= vect_take;
            cc_q     <= cc_in;
            stk_ovf  <= stk_ovf || stk_trip;
        end
    end

`ifdef UCODE_PARITY_EN
    // sticky parity fault on a fetched word
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_err <= 1'b0;
        else
            par_err <= par_err || par_bad;
    end
`endif

    // mapping with an empty opcode register is a software error
    assert property (@(posedge clk) disable iff (rst) (run && map_en) |-> op_full);

    assign seq_i        = (state == ST_JZ) ? 4'(JZ) : pipe[OFS_I +: I_W];
    assign seq_ccen_bar = pipe[OFS_CCEN];
    assign seq_cc_bar   = ~cc_q[pipe[OFS_CCSEL +: CCW]];
    assign seq_rld_bar  = pipe[O_RLD];
    assign seq_ci       = pipe[O_CI];
    assign seq_d        = map_en ? map_q : (vect_en && irq_pend) ? irq_vec : pipe[O_BR +: AW];
    assign ctrl_out     = pipe[O_CTRL +: CTRL_W];
    assign halted       = state == ST_HALT;

endmodule

// File: tb/tb_useq_ctrl_store.sv
// tb_useq_ctrl_store: scoreboard bench for useq_ctrl_store (honours UCODE_PARITY_EN)
module tb_useq_ctrl_store;
    import useq_pkg::*;

    localparam int W = w_of(12, 16, 4);
    localparam int O_I = 0, O_CCEN = 1, O_CC = 2, O_RLD = 3, O_CI = 4, O_D = 5;
    localparam int O_CTRL = 6, O_RDY = 7, O_ACK = 8, O_HLT = 9, O_OVF = 10;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic         clk = 0, rst = 1;
    logic [11:0]  y_in = 0, wr_addr = 0, irq_vec = 0;
    logic         map_en = 0, vect_en = 0, full_in = 0, wr_en = 0, wr_map = 0;
    logic         start = 0, op_valid = 0, irq = 0;
    logic [W-1:0] wr_data = 0;
    logic [7:0]   op_data = 0;
    logic [3:0]   cc_in = 0, seq_i;
    logic         seq_ccen_bar, seq_cc_bar, seq_rld_bar, seq_ci, op_ready, irq_ack, halted, stk_ovf;
    logic [11:0]  seq_d;
    logic [15:0]  ctrl_out;
`ifdef UCODE_PARITY_EN
    logic         par_err;
`endif

    always #5 clk = ~clk;

    useq_ctrl_store dut (
        .clk(clk), .rst(rst), .y_in(y_in), .map_en(map_en), .vect_en(vect_en), .full_in(full_in),
        .seq_i(seq_i), .seq_ccen_bar(seq_ccen_bar), .seq_cc_bar(seq_cc_bar), .seq_rld_bar(seq_rld_bar),
        .seq_ci(seq_ci), .seq_d(seq_d), .ctrl_out(ctrl_out), .wr_en(wr_en), .wr_map(wr_map),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .op_valid(op_valid), .op_data(op_data),
        .op_ready(op_ready), .cc_in(cc_in), .irq(irq), .irq_vec(irq_vec), .irq_ack(irq_ack),
        .halted(halted),
`ifdef UCODE_PARITY_EN
        .par_err(par_err),
`endif
        .stk_ovf(stk_ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] obs(input int sel);
        case (sel)
            O_I:     return 64'(seq_i);
            O_CCEN:  return 64'(seq_ccen_bar);
            O_CC:    return 64'(seq_cc_bar);
            O_RLD:   return 64'(seq_rld_bar);
            O_CI:    return 64'(seq_ci);
            O_D:     return 64'(seq_d);
            O_CTRL:  return 64'(ctrl_out);
            O_RDY:   return 64'(op_ready);
            O_ACK:   return 64'(irq_ack);
            O_HLT:   return 64'(halted);
            O_OVF:   return 64'(stk_ovf);
            default: return '1;
        endcase
    endfunction

    task automatic want(input string tag, input int sel, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic want_hold(input string tag);
        want({tag, "_i"}, O_I, 14);
        want({tag, "_ccen"}, O_CCEN, 1);
        want({tag, "_rld"}, O_RLD, 1);
        want({tag, "_ci"}, O_CI, 0);
        want({tag, "_ctrl"}, O_CTRL, 0);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] mw(input logic [3:0] i, input logic ccen, input logic [1:0] ccsel,
                                        input logic halt, input logic ci, input logic [11:0] br,
                                        input logic [15:0] ctrl);
        logic [37:0] b;
        b = {ctrl, br, halt, ci, 1'b1, ccsel, ccen, i};
`ifdef UCODE_PARITY_EN
        return {^b, b};
`else
        return b;
`endif
    endfunction

    task automatic wr(input logic m, input logic [11:0] a, input logic [W-1:0] d);
        wr_en = 1;
        wr_map = m;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 0;
        wr_map = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        want_hold("rst");
        want("rst_d", O_D, 0);
        want("rst_rdy", O_RDY, 0);
        want("rst_ack", O_ACK, 0);
        want("rst_hlt", O_HLT, 0);
        want("rst_ovf", O_OVF, 0);
        drain();
        rst = 0;
        tick();
        want("rdy_idle", O_RDY, 1);
        drain();
        wr(0, 12'h000, mw(CONT, 1'b1, 2'd0, 1'b0, 1'b1, 12'h000, 16'h0000));
        wr(0, 12'h001, mw(CONT, 1'b1, 2'd0, 1'b1, 1'b1, 12'h000, 16'h0000));
        wr(0, 12'h002, mw(JMAP, 1'b1, 2'd0, 1'b0, 1'b0, 12'h000, 16'h0000));
        wr(0, 12'h004, mw(PUSH, 1'b1, 2'd0, 1'b0, 1'b0, 12'h200, 16'h0000));
        wr(0, 12'h123, mw(CJV,  1'b1, 2'd0, 1'b0, 1'b0, 12'h055, 16'h0000));
        wr(0, 12'h7F0, mw(CJP,  1'b0, 2'd2, 1'b0, 1'b0, 12'h3C0, 16'hBEEF));
        wr(1, 12'h03A, W'(12'h123));
        tick();
        // start: one JZ cycle, then the CONT words, the second carrying HALT
        pulse_start();
        y_in = 0;
        want("jz_i", O_I, 0);
        drain();
        tick();
        want("run0_i", O_I, 14);
        want("run0_ci", O_CI, 1);
        want("run0_hlt", O_HLT, 0);
        drain();
        y_in = 1;
        tick();
        want("run1_ci", O_CI, 1);
        want("run1_hlt", O_HLT, 0);
        drain();
        y_in = 2;
        tick();
        want_hold("halt");
        want("halt_hlt", O_HLT, 1);
        want("halt_d", O_D, 0);
        drain();
        // opcode handshake and mapping
        op_valid = 1;
        op_data = 8'h3A;
        tick();
        op_valid = 0;
        want("op_full_rdy", O_RDY, 0);
        drain();
        pulse_start();
        want("resume_hlt", O_HLT, 0);
        drain();
        tick();
        map_en = 1;
        y_in = 12'h123;
        irq = 1;
        irq_vec = 12'h7F0;
        #1;
        want("map_i", O_I, 2);
        want("map_d", O_D, 12'h123);
        drain();
        tick();
        // vector: pending irq selected onto D, irq held high across the consume edge
        map_en = 0;
        vect_en = 1;
        y_in = 12'h7F0;
        cc_in = 4'b0100;
        #1;
        want("map_rdy", O_RDY, 1);
        want("vec_i", O_I, 6);
        want("vec_d", O_D, 12'h7F0);
        want("vec_ack0", O_ACK, 0);
        drain();
        tick();
        want("ack_pulse", O_ACK, 1);
        want("vec_d_br", O_D, 12'h3C0);
        want("cjp_i", O_I, 3);
        want("cjp_ctrl", O_CTRL, 16'hBEEF);
        want("cjp_ccen", O_CCEN, 0);
        want("cc_true", O_CC, 0);
        drain();
        irq = 0;
        vect_en = 0;
        cc_in = 4'b0000;
        tick();
        want("ack_once", O_ACK, 0);
        want("cc_false", O_CC, 1);
        want("br_d", O_D, 12'h3C0);
        drain();
        // stack guard
        y_in = 12'h004;
        tick();
        want("push_i", O_I, 4);
        want("push_ovf0", O_OVF, 0);
        drain();
        full_in = 1;
        tick();
        full_in = 0;
        want_hold("trip");
        want("trip_ovf", O_OVF, 1);
        want("trip_hlt", O_HLT, 1);
        drain();
        pulse_start();
        y_in = 1;
        want("ovf_sticky", O_OVF, 1);
        want("trip_resume", O_HLT, 0);
        drain();
        repeat (2) tick();
        want("rehalt", O_HLT, 1);
        drain();
        // ignored write during RUN, then asynchronous reset mid-RUN
        pulse_start();
        y_in = 0;
        tick();
        wr(0, 12'h7F0, '1);
        #3;
        rst = 1;
        #1;
        want_hold("arst");
        want("arst_hlt", O_HLT, 0);
        want("arst_ovf", O_OVF, 0);
        want("arst_rdy", O_RDY, 0);
        want("arst_ack", O_ACK, 0);
        drain();
        tick();
        rst = 0;
        tick();
        pulse_start();
        y_in = 0;
        tick();
        y_in = 12'h7F0;
        tick();
        want("rb_ctrl", O_CTRL, 16'hBEEF);
        want("rb_i", O_I, 3);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
